stitch_fpu_rob: RTL and testbench
=================================

# stitch_fpu_rob

Issue-side companion of the Stitch FPU wrapper. It allocates the 7-bit tag for every operation the core sends to the FPU, tracks outstanding operations, and accepts tagged results in any order. Results retire to the FP register-file writeback port in strict issue order. It sits between the FP sequencer and the FPU wrapper: its issue side gates the FPU input handshake, and its response side consumes the FPU output handshake.

## Interface
- `Depth`, 8: reorder slots; power of two, 2..128.
- `FLEN`, 64: result width; matches the FPU wrapper.
- `clk_i` in 1: clock; all state on rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `issue_valid_i` in 1: core offers an FPU operation.
- `issue_ready_o` out 1: operation accepted this cycle.
- `issue_rd_i` in 5: destination FP register of the offered operation.
- `issue_tag_o` out 7: tag to drive on the FPU `tag_i`.
- `fpu_in_valid_o` out 1: to FPU `in_valid_i`.
- `fpu_in_ready_i` in 1: from FPU `in_ready_o`.
- `fpu_out_valid_i` in 1: from FPU `out_valid_o`.
- `fpu_out_ready_o` out 1: to FPU `out_ready_i`.
- `fpu_result_i` in FLEN: FPU result.
- `fpu_status_i` in 5: FPU fflags.
- `fpu_tag_i` in 7: FPU result tag.
- `wb_valid_o` out 1: in-order result available.
- `wb_ready_i` in 1: register file accepts the result.
- `wb_rd_o` out 5: destination register of the result.
- `wb_result_o` out FLEN: result data.
- `wb_status_o` out 5: result fflags.
- `busy_o` out 1: at least one slot allocated.
- `tag_err_o` out 1: sticky illegal-response flag.

## Operation
- State per slot: `alloc`, `done`, `rd[4:0]`, `result`, `status`. Head/tail pointers are `$clog2(Depth)+1` bits, wrap modulo 2*Depth. full = pointer indices equal and MSBs differ; empty = pointers equal.
- Issue:
  - `fpu_in_valid_o = issue_valid_i & ~full & ~rst_i`.
  - `issue_ready_o = fpu_in_ready_i & ~full & ~rst_i`.
  - `issue_tag_o = {0, tail index}`.
  - On fire: set slot `alloc=1`, `done=0`, store `rd`, increment tail.
- Response:
  - `fpu_out_ready_o = ~rst_i`. Every slot is pre-reserved, so responses are never back-pressured.
  - On `fpu_out_valid_i`, a tag is legal iff `tag < Depth`, `alloc=1` and `done=0`. A legal response stores `result`/`status` and sets `done`.
  - An illegal response is dropped and sets `tag_err_o`. Only reset clears it.
- Retire:
  - `wb_valid_o = alloc[head] & done[head]`.
  - `wb_*` are driven from the head slot.
  - On `wb_valid_o & wb_ready_i`: clear `alloc`/`done`, increment head.
- `busy_o = ~empty`.
- Simultaneous events:
  - Issue, response and retire are independent in the same cycle.
  - When full, issue is blocked even if a retire occurs that cycle. `issue_ready_o` never depends on `wb_ready_i`.
  - A response to a slot retiring in the same cycle cannot occur, because a retiring slot is already `done`. Such a response is flagged as illegal.
- Reset mid-operation: all slots are discarded. FPU responses still in flight afterwards hit unallocated slots, set `tag_err_o` and are dropped. The owner flushes or drains the FPU together with this block.

## Timing
- Reset values: all slots free, pointers 0, `wb_valid_o=0`, `busy_o=0`, `tag_err_o=0`. While `rst_i` is high, `issue_ready_o`, `fpu_in_valid_o` and `fpu_out_ready_o` are 0.
- Issue path is combinational: valid/ready pass through in the same cycle, with no added latency.
- Response to writeback: a response accepted in cycle t, for the head slot, gives `wb_valid_o=1` in t+1. A non-head slot waits until it becomes head and `done`.
- Retire throughput: one result per cycle.
- `wb_*` hold stable while `wb_valid_o & ~wb_ready_i`.

## Configuration
- `STITCH_FPU_ROB_BYPASS_EN` defined:
  - A legal response whose tag equals the head index while the head is not `done` is forwarded combinationally. `wb_valid_o=1` in the same cycle t, with `wb_result_o`/`wb_status_o` taken from `fpu_result_i`/`fpu_status_i`.
  - If it retires in t, the slot is freed without ever setting `done`. Otherwise the response is stored normally.
- Not defined: no combinational path from `fpu_*` to `wb_*`. Minimum response-to-writeback latency is 1 cycle.

## Test plan
- Reset, then issue rd=3,4,5 with `fpu_in_ready_i=1` -> tags 0,1,2 in consecutive cycles, `busy_o=1`.
- Respond tags 2,0,1 in successive cycles, `wb_ready_i=1` -> writebacks in order rd=3,4,5 with matching results. Without bypass, rd=3 appears the cycle after tag 0 returns.
- Issue 8 with Depth=8 and no responses -> 9th issue sees `issue_ready_o=0`, `fpu_in_valid_o=0`. One retire re-enables issue next cycle, and the new tag is 0 (wrap).
- `wb_ready_i=0` for 4 cycles with head done -> `wb_*` stable. Responses to later tags are still accepted (`fpu_out_ready_o=1`).
- Response with tag 9 (Depth=8), or tag 1 when unallocated -> dropped, `tag_err_o=1` until reset.
- Bypass build: head tag 0 responds in cycle t with `wb_ready_i=1` -> `wb_valid_o=1` in t with `fpu_result_i`, and head advances in t+1.

Source files
------------

// File: rtl/stitch_fpu_rob.sv
// stitch_fpu_rob: tags FPU operations, accepts out-of-order results and retires them in issue order.
// Optional STITCH_FPU_ROB_BYPASS_EN forwards a head-slot response straight to writeback.
module stitch_fpu_rob #(
  parameter int Depth = 8,
  parameter int FLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [4:0]      issue_rd_i,
  output logic [6:0]      issue_tag_o,
  output logic            fpu_in_valid_o,
  input  logic            fpu_in_ready_i,
  input  logic            fpu_out_valid_i,
  output logic            fpu_out_ready_o,
  input  logic [FLEN-1:0] fpu_result_i,
  input  logic [4:0]      fpu_status_i,
  input  logic [6:0]      fpu_tag_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [4:0]      wb_rd_o,
  output logic [FLEN-1:0] wb_result_o,
  output logic [4:0]      wb_status_o,
  output logic            busy_o,
  output logic            tag_err_o
);
  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] ptr_one = 1;
  logic [AW:0] head, tail;
  logic [AW-1:0] h, t, r;
  logic [Depth-1:0] alloc, done;
  logic [4:0] rd_q [Depth];
  logic [FLEN-1:0] res_q [Depth];
  logic [4:0] st_q [Depth];
  logic full, rsp_v, legal, issue_fire, retire, byp, tag_err;
  assign h = head[AW-1:0];
  assign t = tail[AW-1:0];
  assign r = fpu_tag_i[AW-1:0];
  assign full = (h == t) && (head[AW] != tail[AW]);
  assign fpu_in_valid_o = issue_valid_i & ~full & ~rst_i;
  assign issue_ready_o = fpu_in_ready_i & ~full & ~rst_i;
  assign issue_fire = issue_valid_i & issue_ready_o;
  assign issue_tag_o = 7'(t);
  assign fpu_out_ready_o = ~rst_i;
  assign rsp_v = fpu_out_valid_i & ~rst_i;
  assign legal = ({1'b0, fpu_tag_i} < 8'(Depth)) & alloc[r] & ~done[r];
`ifdef STITCH_FPU_ROB_BYPASS_EN
  assign byp = rsp_v & legal & (r == h);
`else
  assign byp = 1'b0;
`endif
  assign wb_valid_o = (alloc[h] & done[h]) | byp;
  assign wb_rd_o = rd_q[h];
  assign wb_result_o = byp ? fpu_result_i : res_q[h];
  assign wb_status_o = byp ? fpu_status_i : st_q[h];
  assign retire = wb_valid_o & wb_ready_i;
  assign busy_o = head != tail;
  assign tag_err_o = tag_err;
  // retire is applied last so a bypassed head retiring this cycle never stays done
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head <= '0;
      tail <= '0;
      alloc <= '0;
      done <= '0;
      tag_err <= 1'b0;
    end else begin
      if (issue_fire) begin
        alloc[t] <= 1'b1;
        done[t] <= 1'b0;
        tail <= tail + ptr_one;
      end
      if (rsp_v && legal) done[r] <= 1'b1;
      if (rsp_v && !legal) tag_err <= 1'b1;
      if (retire) begin
        alloc[h] <= 1'b0;
        done[h] <= 1'b0;
        head <= head + ptr_one;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (issue_fire) rd_q[t] <= issue_rd_i;
    if (rsp_v && legal) begin
      res_q[r] <= fpu_result_i;
      st_q[r] <= fpu_status_i;
    end
  end
endmodule

// File: tb/tb_stitch_fpu_rob.sv
// tb_stitch_fpu_rob: directed scoreboard bench for stitch_fpu_rob (Depth=8, FLEN=64).
module tb_stitch_fpu_rob;
  logic clk = 1'b0, rst = 1'b1;
  logic issue_valid = 1'b0, issue_ready, fpu_in_valid, fpu_in_ready = 1'b1;
  logic [4:0] issue_rd = '0;
  logic [6:0] issue_tag;
  logic fpu_out_valid = 1'b0, fpu_out_ready;
  logic [63:0] fpu_result = '0;
  logic [4:0] fpu_status = '0;
  logic [6:0] fpu_tag = '0;
  logic wb_valid, wb_ready = 1'b0;
  logic [4:0] wb_rd, wb_status;
  logic [63:0] wb_result;
  logic busy, tag_err;
`ifdef STITCH_FPU_ROB_BYPASS_EN
  localparam bit byp_en = 1'b1;
`else
  localparam bit byp_en = 1'b0;
`endif
  typedef struct {logic [4:0] rd; logic [63:0] res; logic [4:0] st;} exp_t;
  exp_t sb[$];
  int n_tests = 0, n_fail = 0, n_iss = 0;
  logic [6:0] exp_tag = '0;
  logic [63:0] tag_res [128];
  logic [4:0] tag_st [128];

  stitch_fpu_rob #(.Depth(8), .FLEN(64)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_rd_i(issue_rd), .issue_tag_o(issue_tag),
    .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready),
    .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready),
    .fpu_result_i(fpu_result), .fpu_status_i(fpu_status), .fpu_tag_i(fpu_tag),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_rd_o(wb_rd),
    .wb_result_o(wb_result), .wb_status_o(wb_status),
    .busy_o(busy), .tag_err_o(tag_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wb_valid && wb_ready) begin
      if (sb.size() == 0) chk("wb_unexpected", 64'(wb_valid), 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_rd", 64'(wb_rd), 64'(e.rd));
        chk("wb_result", wb_result, e.res);
        chk("wb_status", 64'(wb_status), 64'(e.st));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] rd);
    exp_t e;
    n_iss++;
    tag_res[exp_tag] = {32'hC0DE0000, 32'(n_iss)};
    tag_st[exp_tag] = 5'(n_iss * 3);
    e.rd = rd;
    e.res = tag_res[exp_tag];
    e.st = tag_st[exp_tag];
    sb.push_back(e);
    exp_tag = (exp_tag + 7'd1) & 7'd7;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_rd = rd;
    @(negedge clk);
    chk("issue_ready", 64'(issue_ready), 64'd1);
    chk("issue_tag", 64'(issue_tag), 64'(exp_tag));
    push_exp(rd);
    step();
    issue_valid = 1'b0;
  endtask

  task automatic drive_rsp(input logic [6:0] tg);
    fpu_out_valid = 1'b1;
    fpu_tag = tg;
    fpu_result = tag_res[tg];
    fpu_status = tag_st[tg];
  endtask

  task automatic respond(input logic [6:0] tg);
    drive_rsp(tg);
    step();
    fpu_out_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    issue_valid = 1'b1;
    @(negedge clk);
    chk("rst_issue_ready", 64'(issue_ready), 64'd0);
    chk("rst_fpu_in_valid", 64'(fpu_in_valid), 64'd0);
    chk("rst_fpu_out_ready", 64'(fpu_out_ready), 64'd0);
    step();
    step();
    rst = 1'b0;
    issue_valid = 1'b0;
    exp_tag = '0;
    sb.delete();
    @(negedge clk);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tag_err", 64'(tag_err), 64'd0);
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    chk("drain_left", 64'(sb.size()), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      tag_res[i] = '0;
      tag_st[i] = '0;
    end
    do_reset();
    issue(5'd3);
    issue(5'd4);
    issue(5'd5);
    chk("busy_after_issue", 64'(busy), 64'd1);
    wb_ready = 1'b1;
    respond(7'd2);
    drive_rsp(7'd0);
    @(negedge clk);
    chk("wb_same_cycle", 64'(wb_valid), 64'(byp_en));
    step();
    drive_rsp(7'd1);
    @(negedge clk);
    chk("wb_next_cycle", 64'(wb_valid), 64'd1);
    step();
    fpu_out_valid = 1'b0;
    drain();
    do_reset();
    wb_ready = 1'b0;
    for (int i = 0; i < 8; i++) issue(5'(10 + i));
    issue_valid = 1'b1;
    issue_rd = 5'd9;
    @(negedge clk);
    chk("full_issue_ready", 64'(issue_ready), 64'd0);
    chk("full_fpu_in_valid", 64'(fpu_in_valid), 64'd0);
    step();
    respond(7'd0);
    for (int i = 0; i < 4; i++) begin
      if (i < 2) drive_rsp(7'(i + 1));
      @(negedge clk);
      chk("hold_wb_valid", 64'(wb_valid), 64'd1);
      chk("hold_wb_rd", 64'(wb_rd), 64'(sb[0].rd));
      chk("hold_wb_result", wb_result, sb[0].res);
      chk("hold_wb_status", 64'(wb_status), 64'(sb[0].st));
      chk("hold_fpu_out_ready", 64'(fpu_out_ready), 64'd1);
      chk("hold_issue_ready", 64'(issue_ready), 64'd0);
      step();
      fpu_out_valid = 1'b0;
    end
    wb_ready = 1'b1;
    @(negedge clk);
    chk("retire_cycle_issue_ready", 64'(issue_ready), 64'd0);
    step();
    @(negedge clk);
    chk("reopen_issue_ready", 64'(issue_ready), 64'd1);
    chk("reopen_issue_tag", 64'(issue_tag), 64'd0);
    push_exp(5'd9);
    step();
    issue_valid = 1'b0;
    for (int i = 3; i < 8; i++) respond(7'(i));
    respond(7'd0);
    drain();
    respond(7'd9);
    @(negedge clk);
    chk("err_tag9", 64'(tag_err), 64'd1);
    chk("err_tag9_wb_valid", 64'(wb_valid), 64'd0);
    step();
    step();
    step();
    @(negedge clk);
    chk("err_sticky", 64'(tag_err), 64'd1);
    step();
    do_reset();
    respond(7'd1);
    @(negedge clk);
    chk("err_unalloc", 64'(tag_err), 64'd1);
    chk("err_unalloc_busy", 64'(busy), 64'd0);
    step();
    issue(5'd20);
    respond(7'd0);
    drain();
    chk("err_sticky_after_legal", 64'(tag_err), 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
